// File: rtl/decode_stage.sv
// RV32I(+M) decode stage: combinational decode of the fetched word, a small
// FIFO of decoded entries, valid/ready on both sides, and a saturating
// counter of accepted illegal instructions.
module decode_stage #(
  parameter int DEPTH    = 2,
  parameter int ENABLE_M = 1,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [31:0]      in_pc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_pc,
  output logic [4:0]       out_rs1,
  output logic [4:0]       out_rs2,
  output logic [4:0]       out_rd,
  output logic [31:0]      out_imm,
  output logic [4:0]       out_alu_op,
  output logic [1:0]       out_op1_src,
  output logic [1:0]       out_op2_src,
  output logic [2:0]       out_next_pc,
  output logic [1:0]       out_wb_src,
  output logic [2:0]       out_mem_funct3,
  output logic             out_reg_wren,
  output logic             out_ram_wren,
  output logic             out_illegal,
  output logic [CNT_W-1:0] illegal_cnt
);

  // ALU operator codes; M-extension ops occupy 16..23 as {2'b10, funct3}
  localparam logic [4:0] ALU_OPERATOR_ADD  = 5'd0;
  localparam logic [4:0] ALU_OPERATOR_SUB  = 5'd1;
  localparam logic [4:0] ALU_OPERATOR_SLL  = 5'd2;
  localparam logic [4:0] ALU_OPERATOR_SLT  = 5'd3;
  localparam logic [4:0] ALU_OPERATOR_SLTU = 5'd4;
  localparam logic [4:0] ALU_OPERATOR_XOR  = 5'd5;
  localparam logic [4:0] ALU_OPERATOR_SRL  = 5'd6;
  localparam logic [4:0] ALU_OPERATOR_SRA  = 5'd7;
  localparam logic [4:0] ALU_OPERATOR_OR   = 5'd8;
  localparam logic [4:0] ALU_OPERATOR_AND  = 5'd9;

  localparam logic [1:0] OP1_RS1  = 2'd0;
  localparam logic [1:0] OP1_PC   = 2'd1;
  localparam logic [1:0] OP1_ZERO = 2'd2;

  localparam logic [1:0] OP2_RS2  = 2'd0;
  localparam logic [1:0] OP2_IMM  = 2'd1;
  localparam logic [1:0] OP2_FOUR = 2'd2;

  localparam logic [2:0] NPC_SEQ        = 3'd0;
  localparam logic [2:0] NPC_JAL        = 3'd1;
  localparam logic [2:0] NPC_JALR       = 3'd2;
  localparam logic [2:0] NPC_BR_ZERO    = 3'd3;
  localparam logic [2:0] NPC_BR_NONZERO = 3'd4;

  localparam logic [1:0] WB_ALU = 2'd0;
  localparam logic [1:0] WB_RAM = 2'd1;
  localparam logic [1:0] WB_MDU = 2'd2;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic [4:0]  alu_op;
    logic [1:0]  op1_src;
    logic [1:0]  op2_src;
    logic [2:0]  next_pc;
    logic [1:0]  wb_src;
    logic [2:0]  mem_funct3;
    logic        reg_wren;
    logic        ram_wren;
    logic        illegal;
  } entry_t;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j, imm_sh;

  assign opcode = in_instr[6:0];
  assign funct3 = in_instr[14:12];
  assign funct7 = in_instr[31:25];
  assign imm_i  = {{20{in_instr[31]}}, in_instr[31:20]};
  assign imm_s  = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
  assign imm_b  = {{19{in_instr[31]}}, in_instr[31], in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0};
  assign imm_u  = {in_instr[31:12], 12'b0};
  assign imm_j  = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0};
  assign imm_sh = {27'b0, in_instr[24:20]};

  entry_t dec;
  logic [4:0] base_op;

  // funct3 -> plain ALU op (funct7 alternates handled by the caller)
  always_comb begin
    base_op = ALU_OPERATOR_ADD;
    case (funct3)
      3'b000: base_op = ALU_OPERATOR_ADD;
      3'b001: base_op = ALU_OPERATOR_SLL;
      3'b010: base_op = ALU_OPERATOR_SLT;
      3'b011: base_op = ALU_OPERATOR_SLTU;
      3'b100: base_op = ALU_OPERATOR_XOR;
      3'b101: base_op = ALU_OPERATOR_SRL;
      3'b110: base_op = ALU_OPERATOR_OR;
      default: base_op = ALU_OPERATOR_AND;
    endcase
  end

  // Combinational decode of the offered instruction
  always_comb begin
    dec            = '0;
    dec.pc         = in_pc;
    dec.rs1        = in_instr[19:15];
    dec.rs2        = in_instr[24:20];
    dec.rd         = in_instr[11:7];
    dec.mem_funct3 = funct3;
    dec.alu_op     = ALU_OPERATOR_ADD;
    dec.op1_src    = OP1_RS1;
    dec.op2_src    = OP2_RS2;
    dec.next_pc    = NPC_SEQ;
    dec.wb_src     = WB_ALU;
    case (opcode)
      OPC_OP: begin
        dec.reg_wren = 1'b1;
        if (funct7 == 7'b0000000) begin
          dec.alu_op = base_op;
        end else if (funct7 == 7'b0100000 && funct3 == 3'b000) begin
          dec.alu_op = ALU_OPERATOR_SUB;
        end else if (funct7 == 7'b0100000 && funct3 == 3'b101) begin
          dec.alu_op = ALU_OPERATOR_SRA;
        end else if (funct7 == 7'b0000001 && ENABLE_M != 0) begin
          dec.alu_op = {2'b10, funct3};
          dec.wb_src = WB_MDU;
        end else begin
          dec.illegal = 1'b1;
        end
      end
      OPC_OP_IMM: begin
        dec.reg_wren = 1'b1;
        dec.op2_src  = OP2_IMM;
        dec.imm      = imm_i;
        dec.alu_op   = base_op;
        if (funct3 == 3'b001) begin
          dec.imm = imm_sh;
          if (funct7 != 7'b0000000) dec.illegal = 1'b1;
        end else if (funct3 == 3'b101) begin
          dec.imm = imm_sh;
          if (funct7 == 7'b0100000) dec.alu_op = ALU_OPERATOR_SRA;
          else if (funct7 != 7'b0000000) dec.illegal = 1'b1;
        end
      end
      OPC_LOAD: begin
        dec.reg_wren = 1'b1;
        dec.op2_src  = OP2_IMM;
        dec.imm      = imm_i;
        dec.wb_src   = WB_RAM;
        if (funct3 == 3'b011 || funct3 == 3'b110 || funct3 == 3'b111) dec.illegal = 1'b1;
      end
      OPC_STORE: begin
        dec.ram_wren = 1'b1;
        dec.op2_src  = OP2_IMM;
        dec.imm      = imm_s;
        if (funct3 > 3'b010) dec.illegal = 1'b1;
      end
      OPC_BRANCH: begin
        dec.imm = imm_b;
        case (funct3)
          3'b000: begin dec.alu_op = ALU_OPERATOR_SUB;  dec.next_pc = NPC_BR_ZERO;    end
          3'b001: begin dec.alu_op = ALU_OPERATOR_SUB;  dec.next_pc = NPC_BR_NONZERO; end
          3'b100: begin dec.alu_op = ALU_OPERATOR_SLT;  dec.next_pc = NPC_BR_NONZERO; end
          3'b101: begin dec.alu_op = ALU_OPERATOR_SLT;  dec.next_pc = NPC_BR_ZERO;    end
          3'b110: begin dec.alu_op = ALU_OPERATOR_SLTU; dec.next_pc = NPC_BR_NONZERO; end
          3'b111: begin dec.alu_op = ALU_OPERATOR_SLTU; dec.next_pc = NPC_BR_ZERO;    end
          default: dec.illegal = 1'b1;
        endcase
      end
      OPC_JAL: begin
        dec.reg_wren = 1'b1;
        dec.op1_src  = OP1_PC;
        dec.op2_src  = OP2_FOUR;
        dec.imm      = imm_j;
        dec.next_pc  = NPC_JAL;
      end
      OPC_JALR: begin
        dec.reg_wren = 1'b1;
        dec.op1_src  = OP1_PC;
        dec.op2_src  = OP2_FOUR;
        dec.imm      = imm_i;
        dec.next_pc  = NPC_JALR;
        if (funct3 != 3'b000) dec.illegal = 1'b1;
      end
      OPC_LUI: begin
        dec.reg_wren = 1'b1;
        dec.op1_src  = OP1_ZERO;
        dec.op2_src  = OP2_IMM;
        dec.imm      = imm_u;
      end
      OPC_AUIPC: begin
        dec.reg_wren = 1'b1;
        dec.op1_src  = OP1_PC;
        dec.op2_src  = OP2_IMM;
        dec.imm      = imm_u;
      end
      default: dec.illegal = 1'b1;
    endcase
    // Illegal entries must not change architectural state or redirect fetch
    if (dec.illegal) begin
      dec.reg_wren = 1'b0;
      dec.ram_wren = 1'b0;
      dec.next_pc  = NPC_SEQ;
    end
    // x0 is hardwired; never write it
    if (dec.rd == 5'd0) dec.reg_wren = 1'b0;
  end

  entry_t mem_reg [DEPTH];
  logic [AW-1:0] head_reg, tail_reg;
  logic [AW:0]   count_reg;
  logic          push, pop;

  assign in_ready  = (count_reg < DEPTH_C);
  assign out_valid = (count_reg != '0);
  assign push      = in_valid && in_ready && !flush;
  assign pop       = out_valid && out_ready && !flush;

  // One storage slot per buffer entry, written when it is the tail
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
      always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) mem_reg[gi] <= '0;
        else if (push && tail_reg == AW'(gi)) mem_reg[gi] <= dec;
      end
    end
  endgenerate

  // Pointer and occupancy bookkeeping; flush empties the buffer
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
    end else if (flush) begin
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
    end else begin
      if (push) tail_reg <= tail_reg + 1'b1;
      if (pop)  head_reg <= head_reg + 1'b1;
      case ({push, pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  // Saturating count of accepted illegal instructions (survives flush)
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) illegal_cnt <= '0;
    else if (push && dec.illegal && illegal_cnt != {CNT_W{1'b1}}) illegal_cnt <= illegal_cnt + 1'b1;
  end

  entry_t head;
  assign head = out_valid ? mem_reg[head_reg] : '0;

  assign out_pc         = head.pc;
  assign out_rs1        = head.rs1;
  assign out_rs2        = head.rs2;
  assign out_rd         = head.rd;
  assign out_imm        = head.imm;
  assign out_alu_op     = head.alu_op;
  assign out_op1_src    = head.op1_src;
  assign out_op2_src    = head.op2_src;
  assign out_next_pc    = head.next_pc;
  assign out_wb_src     = head.wb_src;
  assign out_mem_funct3 = head.mem_funct3;
  assign out_reg_wren   = head.reg_wren;
  assign out_ram_wren   = head.ram_wren;
  assign out_illegal    = head.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage: two instances (M enabled / disabled)
// share stimulus; each has its own expected-entry queue and illegal count.
module tb_decode_stage;
  localparam int DEPTH = 2;

  // Bench-side encodings
  localparam logic [4:0] A_ADD = 5'd0, A_SUB = 5'd1, A_SLL = 5'd2, A_SLT = 5'd3, A_SLTU = 5'd4;
  localparam logic [4:0] A_XOR = 5'd5, A_SRL = 5'd6, A_SRA = 5'd7, A_OR = 5'd8, A_AND = 5'd9;
  localparam logic [1:0] S1_RS1 = 2'd0, S1_PC = 2'd1, S1_ZERO = 2'd2;
  localparam logic [1:0] S2_RS2 = 2'd0, S2_IMM = 2'd1, S2_FOUR = 2'd2;
  localparam logic [2:0] N_SEQ = 3'd0, N_JAL = 3'd1, N_JALR = 3'd2, N_BZ = 3'd3, N_BNZ = 3'd4;
  localparam logic [1:0] W_ALU = 2'd0, W_RAM = 2'd1, W_MDU = 2'd2;

  typedef struct packed {
    logic        illegal;
    logic [31:0] pc;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic [4:0]  alu;
    logic [1:0]  op1;
    logic [1:0]  op2;
    logic [2:0]  nxt;
    logic [1:0]  wb;
    logic [2:0]  f3;
    logic        reg_wren;
    logic        ram_wren;
  } exp_t;

  logic clk, rstn, flush, in_valid, out_ready;
  logic [31:0] in_instr, in_pc;

  logic        ir0, ov0, rw0, mw0, il0;
  logic [31:0] pc0, imm0;
  logic [4:0]  rs10, rs20, rd0, alu0;
  logic [1:0]  o10, o20, wb0;
  logic [2:0]  np0, f30;
  logic [15:0] cnt0;

  logic        ir1, ov1, rw1, mw1, il1;
  logic [31:0] pc1, imm1;
  logic [4:0]  rs11, rs21, rd1, alu1;
  logic [1:0]  o11, o21, wb1;
  logic [2:0]  np1, f31;
  logic [15:0] cnt1;

  decode_stage #(.DEPTH(DEPTH), .ENABLE_M(1), .CNT_W(16)) dut_m (
    .clk(clk), .rstn(rstn), .flush(flush), .in_valid(in_valid), .in_ready(ir0),
    .in_instr(in_instr), .in_pc(in_pc), .out_valid(ov0), .out_ready(out_ready),
    .out_pc(pc0), .out_rs1(rs10), .out_rs2(rs20), .out_rd(rd0), .out_imm(imm0),
    .out_alu_op(alu0), .out_op1_src(o10), .out_op2_src(o20), .out_next_pc(np0),
    .out_wb_src(wb0), .out_mem_funct3(f30), .out_reg_wren(rw0), .out_ram_wren(mw0),
    .out_illegal(il0), .illegal_cnt(cnt0));

  decode_stage #(.DEPTH(DEPTH), .ENABLE_M(0), .CNT_W(16)) dut_nm (
    .clk(clk), .rstn(rstn), .flush(flush), .in_valid(in_valid), .in_ready(ir1),
    .in_instr(in_instr), .in_pc(in_pc), .out_valid(ov1), .out_ready(out_ready),
    .out_pc(pc1), .out_rs1(rs11), .out_rs2(rs21), .out_rd(rd1), .out_imm(imm1),
    .out_alu_op(alu1), .out_op1_src(o11), .out_op2_src(o21), .out_next_pc(np1),
    .out_wb_src(wb1), .out_mem_funct3(f31), .out_reg_wren(rw1), .out_ram_wren(mw1),
    .out_illegal(il1), .illegal_cnt(cnt1));

  logic [98:0] obs_w [2];
  logic        in_ready_w [2];
  logic        out_valid_w [2];
  logic [15:0] cnt_w [2];

  assign obs_w[0] = {il0, pc0, rs10, rs20, rd0, imm0, alu0, o10, o20, np0, wb0, f30, rw0, mw0};
  assign obs_w[1] = {il1, pc1, rs11, rs21, rd1, imm1, alu1, o11, o21, np1, wb1, f31, rw1, mw1};
  assign in_ready_w[0] = ir0;  assign in_ready_w[1] = ir1;
  assign out_valid_w[0] = ov0; assign out_valid_w[1] = ov1;
  assign cnt_w[0] = cnt0;      assign cnt_w[1] = cnt1;

  int n_cmp = 0;
  int n_bad = 0;
  exp_t exp_q [2][$];
  logic [15:0] cnt_m [2];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s obs=%h exp=%h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference decode, organised by opcode
  function automatic exp_t model(input logic [31:0] w, input logic [31:0] pc, input bit en_m);
    exp_t e;
    logic [2:0] f3;
    logic [6:0] f7;
    bit bad;
    logic [4:0] plain;
    f3 = w[14:12];
    f7 = w[31:25];
    bad = 1'b0;
    e = '0;
    e.pc = pc; e.rs1 = w[19:15]; e.rs2 = w[24:20]; e.rd = w[11:7]; e.f3 = f3;
    case (f3)
      3'd0: plain = A_ADD;  3'd1: plain = A_SLL; 3'd2: plain = A_SLT; 3'd3: plain = A_SLTU;
      3'd4: plain = A_XOR;  3'd5: plain = A_SRL; 3'd6: plain = A_OR;  default: plain = A_AND;
    endcase
    case (w[6:0])
      7'h33: begin
        e.reg_wren = 1;
        if (f7 == 7'h00) e.alu = plain;
        else if (f7 == 7'h20 && f3 == 3'd0) e.alu = A_SUB;
        else if (f7 == 7'h20 && f3 == 3'd5) e.alu = A_SRA;
        else if (f7 == 7'h01 && en_m) begin e.alu = 5'd16 + 5'(f3); e.wb = W_MDU; end
        else bad = 1;
      end
      7'h13: begin
        e.reg_wren = 1; e.op2 = S2_IMM; e.alu = plain;
        e.imm = {{20{w[31]}}, w[31:20]};
        if (f3 == 3'd1 || f3 == 3'd5) begin
          e.imm = 32'(w[24:20]);
          if (f3 == 3'd5 && f7 == 7'h20) e.alu = A_SRA;
          else if (f7 != 7'h00) bad = 1;
        end
      end
      7'h03: begin
        e.reg_wren = 1; e.op2 = S2_IMM; e.wb = W_RAM; e.imm = {{20{w[31]}}, w[31:20]};
        bad = (f3 == 3'd3) || (f3 >= 3'd6);
      end
      7'h23: begin
        e.ram_wren = 1; e.op2 = S2_IMM; e.imm = {{20{w[31]}}, w[31:25], w[11:7]};
        bad = (f3 > 3'd2);
      end
      7'h63: begin
        e.imm = {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
        e.alu = (f3[2:1] == 2'b00) ? A_SUB : (f3[1] ? A_SLTU : A_SLT);
        e.nxt = (f3[0] == f3[2]) ? N_BZ : N_BNZ;
        bad = (f3[2:1] == 2'b01);
      end
      7'h6F: begin
        e.reg_wren = 1; e.op1 = S1_PC; e.op2 = S2_FOUR; e.nxt = N_JAL;
        e.imm = {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
      end
      7'h67: begin
        e.reg_wren = 1; e.op1 = S1_PC; e.op2 = S2_FOUR; e.nxt = N_JALR;
        e.imm = {{20{w[31]}}, w[31:20]};
        bad = (f3 != 3'd0);
      end
      7'h37: begin e.reg_wren = 1; e.op1 = S1_ZERO; e.op2 = S2_IMM; e.imm = {w[31:12], 12'h0}; end
      7'h17: begin e.reg_wren = 1; e.op1 = S1_PC;   e.op2 = S2_IMM; e.imm = {w[31:12], 12'h0}; end
      default: bad = 1;
    endcase
    if (bad) begin
      e.illegal = 1; e.reg_wren = 0; e.ram_wren = 0; e.nxt = N_SEQ;
    end
    if (e.rd == 5'd0) e.reg_wren = 0;
    return e;
  endfunction

  // For illegal entries only the architecturally relevant fields matter
  function automatic logic [98:0] keep(input logic [98:0] v, input logic ill);
    exp_t m;
    m = '1;
    if (ill) begin
      m = '0;
      m.illegal = 1; m.pc = '1; m.nxt = '1; m.reg_wren = 1; m.ram_wren = 1;
    end
    return v & m;
  endfunction

  exp_t mon_e;

  // Scoreboard: compare head each cycle, pop on consume, push on accept
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (!rstn) begin
        check_val("rst_out", 128'(obs_w[k]), 128'd0);
        check_val("rst_valid", 128'(out_valid_w[k]), 128'd0);
        check_val("rst_cnt", 128'(cnt_w[k]), 128'd0);
        exp_q[k].delete();
        cnt_m[k] = '0;
      end else begin
        check_val("in_ready", 128'(in_ready_w[k]), 128'(exp_q[k].size() < DEPTH));
        check_val("out_valid", 128'(out_valid_w[k]), 128'(exp_q[k].size() != 0));
        check_val("illegal_cnt", 128'(cnt_w[k]), 128'(cnt_m[k]));
        if (!out_valid_w[k]) begin
          check_val("empty_zero", 128'(obs_w[k]), 128'd0);
        end else if (exp_q[k].size() > 0) begin
          mon_e = exp_q[k][0];
          check_val(out_ready ? "entry" : "hold", 128'(keep(obs_w[k], mon_e.illegal)),
                    128'(keep(mon_e, mon_e.illegal)));
          if (out_ready && !flush) begin
            void'(exp_q[k].pop_front());
            $display("txn dut%0d pc=%h illegal=%0d alu=%0d imm=%h", k, mon_e.pc, mon_e.illegal,
                     mon_e.alu, mon_e.imm);
          end
        end
        if (flush) begin
          exp_q[k].delete();
        end else if (in_valid && in_ready_w[k]) begin
          mon_e = model(in_instr, in_pc, (k == 0));
          exp_q[k].push_back(mon_e);
          if (mon_e.illegal && cnt_m[k] != 16'hFFFF) cnt_m[k] = cnt_m[k] + 16'd1;
        end
      end
    end
  end

  task automatic push(input logic [31:0] w, input logic [31:0] pc);
    bit acc;
    acc = 1'b0;
    in_valid = 1'b1; in_instr = w; in_pc = pc;
    for (int c = 0; c < 50 && !acc; c++) begin
      @(negedge clk);
      if (in_ready_w[0]) acc = 1'b1;
    end
    check_val("push_accept", 128'(acc), 128'd1);
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  logic [31:0] tbl [20];

  initial begin
    tbl = '{32'h002081B3, 32'hFFF00093, 32'h123452B7, 32'h00000013, 32'hFE209EE3,
            32'h022081B3, 32'hFFFFFFFF, 32'h402081B3, 32'h402091B3, 32'h0020A423,
            32'hFFC0A203, 32'hFFC0B203, 32'h010000EF, 32'h00008067, 32'h00009067,
            32'h00001397, 32'h4032D313, 32'h40329313, 32'h00208463, 32'h0020A463};
    rstn = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_instr = '0; in_pc = '0;
    repeat (3) @(posedge clk);
    #1 rstn = 1'b1;
    idle(1);

    // Streaming decode with sustained out_ready
    for (int i = 0; i < 20; i++) push(tbl[i], 32'h100 + 32'(4 * i));
    push(32'h0220C1B3, 32'h150);
    push(32'h0000000F, 32'h154);
    idle(3);

    // Back-pressure: two accepted, third waits while the head holds
    out_ready = 1'b0;
    push(32'h002081B3, 32'h400);
    push(32'hFFF00093, 32'h404);
    in_valid = 1'b1; in_instr = 32'h123452B7; in_pc = 32'h408;
    repeat (4) @(posedge clk);
    #1 out_ready = 1'b1;
    push(32'h123452B7, 32'h408);
    idle(4);

    // Flush with a full buffer and in_valid high
    out_ready = 1'b0;
    push(32'h002081B3, 32'h500);
    push(32'h00208463, 32'h504);
    in_valid = 1'b1; in_instr = 32'hFFFFFFFF; in_pc = 32'h508; flush = 1'b1;
    @(posedge clk); #1 flush = 1'b0; in_valid = 1'b0;
    idle(2);

    // Flush with room: the illegal word offered in the flush cycle is dropped
    push(32'h00000013, 32'h600);
    in_valid = 1'b1; in_instr = 32'hFFFFFFFF; in_pc = 32'h604; flush = 1'b1;
    @(posedge clk); #1 flush = 1'b0; in_valid = 1'b0;
    out_ready = 1'b1;
    idle(2);
    push(32'h002081B3, 32'h700);
    idle(3);

    // Asynchronous reset mid-stream
    out_ready = 1'b0;
    push(32'h022081B3, 32'h800);
    push(32'hFFFFFFFF, 32'h804);
    in_valid = 1'b1; in_instr = 32'hFFFFFFFF; in_pc = 32'h808;
    rstn = 1'b0;
    @(posedge clk); #1 rstn = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    idle(2);
    push(32'hFFFFFFFF, 32'h900);
    push(32'h00000013, 32'h904);
    idle(5);

    check_val("drain0", 128'(exp_q[0].size()), 128'd0);
    check_val("drain1", 128'(exp_q[1].size()), 128'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "timeout");
  end

endmodule
